// File: rtl/midi_pkg.sv
// Shared constants and state types for the MIDI key decoder slice.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHPRESS  = 4'hD;
    localparam logic [3:0] SYS      = 4'hF;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        RS_NONE,
        RS_ON,
        RS_OFF,
        RS_SKIP
    } run_status_t;

    // 0xF8-0xFF may interleave anywhere without disturbing a message.
    function automatic logic is_realtime(input logic [7:0] b);
        return b[7:3] == 5'b11111;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte/framing strobes.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_done_q;
    logic             frame_err_q;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A start bit that has vanished by mid-bit is treated as noise and dropped silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UART_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (!ce) begin
                state_q   <= UART_IDLE;
                cnt_q     <= '0;
                bit_idx_q <= '0;
            end else begin
                case (state_q)
                    UART_IDLE: begin
                        cnt_q <= '0;
                        if (rx_prev_q && !rx_sync_q) state_q <= UART_START;
                    end
                    UART_START: begin
                        if (cnt_q == HALF_LAST) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= rx_sync_q ? UART_IDLE : UART_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    UART_DATA: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_sync_q, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) state_q <= UART_STOP;
                            else bit_idx_q <= bit_idx_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    UART_STOP: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q       <= '0;
                            state_q     <= UART_IDLE;
                            byte_done_q <= rx_sync_q;
                            frame_err_q <= !rx_sync_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= UART_IDLE;
                endcase
            end
        end
    end

    assign rx_byte   = shift_q;
    assign byte_done = byte_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/midi_key_decoder.sv
// MIDI Note On/Off decoder for one channel driving a monophonic last-note-priority key gate.
module midi_key_decoder
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 31250
) (
    input  logic       Sys_clk,
    input  logic       Midi_rst_n,
    input  logic       Midi_ce,
    input  logic       Midi_rx,
    input  logic [3:0] Midi_chan,
    output logic       Syn_key,
    output logic [6:0] Note,
    output logic [6:0] Velocity,
    output logic       Note_valid,
    output logic       Rx_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       frame_err;

    midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk       (Sys_clk),
        .rst_n     (Midi_rst_n),
        .ce        (Midi_ce),
        .rx        (Midi_rx),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    run_status_t rs_q, rs_d;
    logic        skip_one_q, skip_one_d;
    logic        data_cnt_q, data_cnt_d;
    logic [6:0]  key_q, key_d;
    logic        syn_key_q, syn_key_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;
    logic        note_valid_q, note_valid_d;
    logic        rx_err_q, rx_err_d;
    logic        gap_q, gap_d;

    logic [3:0]  hi_nib;
    logic [3:0]  lo_nib;
    assign hi_nib = rx_byte[7:4];
    assign lo_nib = rx_byte[3:0];

    // A new note while the gate is held drops it for exactly one cycle (gap_q) so the envelope retriggers.
    always_comb begin
        rs_d         = rs_q;
        skip_one_d   = skip_one_q;
        data_cnt_d   = data_cnt_q;
        key_d        = key_q;
        syn_key_d    = syn_key_q;
        note_d       = note_q;
        vel_d        = vel_q;
        note_valid_d = 1'b0;
        rx_err_d     = 1'b0;
        gap_d        = 1'b0;

        if (gap_q) syn_key_d = 1'b1;

        if (Midi_ce) begin
            rx_err_d = frame_err;
            if (byte_done) begin
                if (rx_byte[7]) begin
                    if (!is_realtime(rx_byte)) begin
                        data_cnt_d = 1'b0;
                        if (hi_nib == SYS) begin
                            rs_d = RS_NONE;
                        end else if (lo_nib == Midi_chan && hi_nib == NOTE_OFF) begin
                            rs_d = RS_OFF;
                        end else if (lo_nib == Midi_chan && hi_nib == NOTE_ON) begin
                            rs_d = RS_ON;
                        end else begin
                            rs_d       = RS_SKIP;
                            skip_one_d = (hi_nib == PROG) || (hi_nib == CHPRESS);
                        end
                    end
                end else if (rs_q != RS_NONE) begin
                    if (!data_cnt_q) begin
                        key_d      = rx_byte[6:0];
                        data_cnt_d = !(rs_q == RS_SKIP && skip_one_q);
                    end else begin
                        data_cnt_d = 1'b0;
                        if (rs_q == RS_ON && rx_byte[6:0] != 7'd0) begin
                            note_d       = key_q;
                            vel_d        = rx_byte[6:0];
                            note_valid_d = 1'b1;
                            syn_key_d    = !syn_key_q;
                            gap_d        = syn_key_q;
                        end else if ((rs_q == RS_ON || rs_q == RS_OFF)
                                     && key_q == note_q && syn_key_q) begin
                            syn_key_d = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Midi_rst_n) begin
        if (!Midi_rst_n) begin
            rs_q         <= RS_NONE;
            skip_one_q   <= 1'b0;
            data_cnt_q   <= 1'b0;
            key_q        <= '0;
            syn_key_q    <= 1'b0;
            note_q       <= '0;
            vel_q        <= '0;
            note_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
            gap_q        <= 1'b0;
        end else begin
            rs_q         <= rs_d;
            skip_one_q   <= skip_one_d;
            data_cnt_q   <= data_cnt_d;
            key_q        <= key_d;
            syn_key_q    <= syn_key_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            note_valid_q <= note_valid_d;
            rx_err_q     <= rx_err_d;
            gap_q        <= gap_d;
        end
    end

    assign Syn_key    = syn_key_q;
    assign Note       = note_q;
    assign Velocity   = vel_q;
    assign Note_valid = note_valid_q;
    assign Rx_err     = rx_err_q;

endmodule

// File: tb/tb_midi_key_decoder.sv
// Randomized serial-MIDI bench with a message-level reference model and per-cycle output checking.
module tb_midi_key_decoder;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Cycles from driving a start bit to the outputs reflecting that byte.
    localparam int LAT  = 4 + HALF + 9 * CPB;

    localparam int M_NONE = 0;
    localparam int M_ON   = 1;
    localparam int M_OFF  = 2;
    localparam int M_SKIP = 3;

    logic       Sys_clk = 1'b0;
    logic       Midi_rst_n;
    logic       Midi_ce;
    logic       Midi_rx;
    logic [3:0] Midi_chan;
    logic       Syn_key;
    logic [6:0] Note;
    logic [6:0] Velocity;
    logic       Note_valid;
    logic       Rx_err;

    midi_key_decoder #(.CLK_HZ(500_000), .BAUD(31250)) dut (
        .Sys_clk    (Sys_clk),
        .Midi_rst_n (Midi_rst_n),
        .Midi_ce    (Midi_ce),
        .Midi_rx    (Midi_rx),
        .Midi_chan  (Midi_chan),
        .Syn_key    (Syn_key),
        .Note       (Note),
        .Velocity   (Velocity),
        .Note_valid (Note_valid),
        .Rx_err     (Rx_err)
    );

    always #5 Sys_clk = ~Sys_clk;

    int testsRun  = 0;
    int failCount = 0;
    int unsigned cyc = 0;
    bit checkEn = 1'b0;

    typedef struct {
        int unsigned due;
        int          b;
        bit          err;
    } ev_t;
    ev_t evq[$];

    int  rs;
    int  needLen;
    int  msg[$];
    bit  expSyn, expGap, expValid, expErr;
    int  expNote, expVel;

    int validPulses = 0;
    int errPulses   = 0;
    int lowRun      = 0;
    int lastGap     = 0;

    always @(posedge Sys_clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void modelReset();
        evq.delete();
        msg.delete();
        rs       = M_NONE;
        needLen  = 2;
        expSyn   = 1'b0;
        expGap   = 1'b0;
        expValid = 1'b0;
        expErr   = 1'b0;
        expNote  = 0;
        expVel   = 0;
    endfunction

    function automatic void modelByte(input int b);
        int hi, ch;
        if (b >= 'hF8) return;
        if (b >= 'h80) begin
            msg.delete();
            hi = b / 16;
            ch = b % 16;
            needLen = 2;
            if (hi == 15) rs = M_NONE;
            else if (hi == 8 && ch == int'(Midi_chan)) rs = M_OFF;
            else if (hi == 9 && ch == int'(Midi_chan)) rs = M_ON;
            else begin
                rs = M_SKIP;
                if (hi == 12 || hi == 13) needLen = 1;
            end
        end else if (rs != M_NONE) begin
            msg.push_back(b);
            if (msg.size() == needLen) begin
                if (rs == M_ON && msg[1] != 0) begin
                    expNote  = msg[0];
                    expVel   = msg[1];
                    expValid = 1'b1;
                    expGap   = expSyn;
                    expSyn   = !expSyn;
                end else if (rs != M_SKIP && msg[0] == expNote && expSyn) begin
                    expSyn = 1'b0;
                end
                msg.delete();
            end
        end
    endfunction

    always @(negedge Sys_clk) begin : compareProc
        ev_t ev;
        if (checkEn) begin
            expValid = 1'b0;
            expErr   = 1'b0;
            if (expGap) begin
                expSyn = 1'b1;
                expGap = 1'b0;
            end
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                ev = evq.pop_front();
                if (ev.err) expErr = 1'b1;
                else modelByte(ev.b);
            end
            checkOutput("Syn_key",    int'(Syn_key),    int'(expSyn));
            checkOutput("Note",       int'(Note),       expNote);
            checkOutput("Velocity",   int'(Velocity),   expVel);
            checkOutput("Note_valid", int'(Note_valid), int'(expValid));
            checkOutput("Rx_err",     int'(Rx_err),     int'(expErr));
        end
    end

    always @(negedge Sys_clk) begin
        if (Note_valid) validPulses++;
        if (Rx_err) errPulses++;
        if (!Syn_key) lowRun++;
        else begin
            if (lowRun > 0) lastGap = lowRun;
            lowRun = 0;
        end
    end

    // dataBits < 8 abandons the byte part-way with the line left at the last bit.
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int dataBits);
        int unsigned n;
        @(negedge Sys_clk);
        Midi_rx = 1'b0;
        n = cyc;
        repeat (CPB) @(negedge Sys_clk);
        for (int i = 0; i < dataBits; i++) begin
            Midi_rx = b[i];
            repeat (CPB) @(negedge Sys_clk);
        end
        if (dataBits < 8) return;
        Midi_rx = stopBit;
        evq.push_back('{due: n + LAT, b: int'(b), err: !stopBit});
        repeat (CPB) @(negedge Sys_clk);
        Midi_rx = 1'b1;
        repeat (stopBit ? 2 : CPB) @(negedge Sys_clk);
    endtask

    task automatic applyStimulusSeq(input logic [7:0] q[$]);
        foreach (q[i]) applyStimulus(q[i], 1'b1, 8);
    endtask

    task automatic checkState(input string tag, input int syn, input int note, input int vel);
        checkOutput({tag, ".Syn_key"},  int'(Syn_key),  syn);
        checkOutput({tag, ".Note"},     int'(Note),     note);
        checkOutput({tag, ".Velocity"}, int'(Velocity), vel);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int r;
        Midi_rst_n = 1'b0;
        Midi_ce    = 1'b1;
        Midi_rx    = 1'b1;
        Midi_chan  = 4'd0;
        modelReset();
        repeat (3) @(negedge Sys_clk);
        checkState("reset", 0, 0, 0);
        checkOutput("reset.Note_valid", int'(Note_valid), 0);
        checkOutput("reset.Rx_err", int'(Rx_err), 0);
        Midi_rst_n = 1'b1;
        checkEn = 1'b1;
        repeat (4) @(negedge Sys_clk);

        applyStimulusSeq('{8'h90, 8'h3C, 8'h64});
        checkState("t1", 1, 60, 100);
        checkOutput("t1.validPulses", validPulses, 1);

        applyStimulusSeq('{8'h40, 8'h50});
        checkState("t2", 1, 64, 80);
        checkOutput("t2.validPulses", validPulses, 2);
        checkOutput("t2.gapCycles", lastGap, 1);

        applyStimulusSeq('{8'h3C, 8'h00});
        checkState("t3a", 1, 64, 80);
        applyStimulusSeq('{8'h80, 8'h40, 8'h00});
        checkState("t3b", 0, 64, 80);

        applyStimulusSeq('{8'h91, 8'h3C, 8'h64});
        checkState("t4a", 0, 64, 80);
        applyStimulusSeq('{8'h90, 8'hF8, 8'h30, 8'hFE, 8'h7F});
        checkState("t4b", 1, 48, 127);
        checkOutput("t4.validPulses", validPulses, 3);

        applyStimulus(8'h3E, 1'b1, 8);
        applyStimulus(8'h55, 1'b0, 8);
        applyStimulus(8'h20, 1'b1, 8);
        checkState("t5", 1, 62, 32);
        checkOutput("t5.errPulses", errPulses, 1);
        checkOutput("t5.validPulses", validPulses, 4);
        checkOutput("t5.gapCycles", lastGap, 1);

        @(negedge Sys_clk);
        Midi_rx = 1'b0;
        repeat (4) @(negedge Sys_clk);
        Midi_rx = 1'b1;
        repeat (3 * CPB) @(negedge Sys_clk);
        // A 1.2-bit low can only ever frame as 0xFF, a real-time byte with no effect.
        Midi_rx = 1'b0;
        repeat (CPB * 6 / 5) @(negedge Sys_clk);
        Midi_rx = 1'b1;
        repeat (11 * CPB) @(negedge Sys_clk);
        checkState("t5g", 1, 62, 32);
        checkOutput("t5g.errPulses", errPulses, 1);
        checkOutput("t5g.validPulses", validPulses, 4);

        applyStimulus(8'hA5, 1'b1, 3);
        #2;
        Midi_rst_n = 1'b0;
        modelReset();
        #1;
        checkState("t6rst", 0, 0, 0);
        checkOutput("t6rst.Note_valid", int'(Note_valid), 0);
        repeat (3) @(negedge Sys_clk);
        Midi_rx = 1'b1;
        Midi_rst_n = 1'b1;
        repeat (4) @(negedge Sys_clk);

        applyStimulus(8'h90, 1'b1, 8);
        applyStimulus(8'h3C, 1'b1, 4);
        Midi_ce = 1'b0;
        Midi_rx = 1'b1;
        repeat (20) @(negedge Sys_clk);
        Midi_ce = 1'b1;
        repeat (4) @(negedge Sys_clk);
        applyStimulusSeq('{8'h90, 8'h3C, 8'h64});
        checkState("t6ce", 1, 60, 100);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) Midi_chan = 4'($urandom_range(0, 1));
            if (r < 18) begin
                case ($urandom_range(0, 8))
                    0, 1:    b = {4'h9, 4'($urandom_range(0, 1))};
                    2:       b = {4'h8, 4'($urandom_range(0, 1))};
                    3:       b = {4'hA, 4'($urandom_range(0, 1))};
                    4:       b = {4'hC, 4'($urandom_range(0, 1))};
                    5:       b = {4'hD, 4'($urandom_range(0, 1))};
                    6:       b = {4'hE, 4'($urandom_range(0, 1))};
                    default: b = 8'($urandom_range('hF0, 'hF7));
                endcase
            end else if (r < 24) begin
                b = 8'($urandom_range('hF8, 'hFF));
            end else begin
                b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(60, 63));
            end
            applyStimulus(b, ($urandom_range(0, 19) != 0), 8);
            repeat ($urandom_range(0, 3)) @(negedge Sys_clk);
        end

        repeat (5) @(negedge Sys_clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/midi_key_decoder.md
Name: midi_key_decoder

Overview:
- Front end of the synth voice: receives a MIDI serial stream (31250 baud, 8N1) and decodes Note On / Note Off messages for one channel.
- Drives the single-voice key gate (Syn_key), note number and velocity consumed by the Envelope and oscillator blocks.
- Last-note priority, monophonic.
- Guarantees a rising edge on Syn_key for every new note so the Envelope retriggers.

Parameters:
- CLK_HZ, 100_000_000, Sys_clk frequency in Hz.
- BAUD, 31250, MIDI bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (3200), derived local constant; must be >= 4.

Ports:
- Sys_clk  in  1  system clock; all logic on its rising edge.
- Midi_rst_n  in  1  asynchronous, active-low reset.
- Midi_ce  in  1  block enable.
- Midi_rx  in  1  raw MIDI serial input, asynchronous, idle high.
- Midi_chan  in  4  MIDI channel to accept (0-15).
- Syn_key  out  1  key gate to Envelope; 1 while a note is held.
- Note  out  7  last accepted note number.
- Velocity  out  7  last accepted Note On velocity.
- Note_valid  out  1  one-cycle pulse when Note/Velocity update.
- Rx_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Clocking and reset: one clock, Sys_clk. Reset is asynchronous and active-low on Midi_rst_n.
- Reset values: Syn_key=0, Note=0, Velocity=0, Note_valid=0, Rx_err=0. UART is IDLE; running status is NONE; data count is 0.
- Input sync: Midi_rx passes through a 2-FF synchronizer, reset value 1. Total input latency is 2 cycles.
- UART states are IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START waits CLKS_PER_BIT/2 cycles, then samples the line. Low -> DATA. High -> IDLE (glitch rejected, no error).
  - DATA samples every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP samples once more. High -> byte_done pulse with the byte, then IDLE. Low -> Rx_err pulse, byte discarded, IDLE; parser state is untouched.
- Parser, status bytes (bit7=1):
  - 0xF8-0xFF (real-time): ignored entirely; running status and data count are preserved.
  - 0xF0-0xF7: running status = NONE.
  - 0x8n/0x9n with n==Midi_chan: running status = OFF/ON.
  - Any other channel-voice status (0x8-0xE on another channel, or 0xA-0xE on this channel): running status = SKIP, with the expected data length (1 for 0xC/0xD, else 2).
  - Every status byte except real-time clears the data count.
- Parser, data bytes:
  - Under NONE: ignored.
  - Otherwise: the first data byte is latched as key. Message completes on the 2nd data byte (1st for 1-byte SKIP), and the count returns to 0 (running status retained).
- Message completion actions:
  - ON with vel>0, Syn_key=0: next cycle Note=key, Velocity=vel, Syn_key=1, Note_valid=1.
  - ON with vel>0, Syn_key=1: next cycle Syn_key=0, Note/Velocity update, Note_valid=1. The following cycle Syn_key=1. The low gap is exactly 1 cycle, including same-note retrigger.
  - OFF, or ON with vel==0: if key==Note and Syn_key=1, Syn_key=0 next cycle. Otherwise no effect.
  - SKIP: no output effect.
- Latency: outputs change 1 cycle after the STOP-bit sample of the final byte.
- Midi_ce=0:
  - UART synchronously returns to IDLE (partial byte dropped) and counters are held at 0.
  - Parser registers and outputs hold their values.
  - No pulses are issued while Midi_ce=0.
  - A pending retrigger gap completes regardless.
- Midi_chan change: takes effect on the next status byte; running status already latched is not re-evaluated.
- Reset mid-byte or mid-gap: all state returns to reset values immediately.

Decomposition:
- Package midi_pkg:
  - status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG=4'hC, CHPRESS=4'hD, SYS=4'hF)
  - UART state enum
  - running-status enum (NONE, ON, OFF, SKIP)
- Sub-module midi_uart_rx: synchronizer + UART FSM. Outputs are byte[7:0], byte_done, frame_err.
- The parser and gate logic stay in the top module.

Test Plan:
1. Midi_chan=0; send 0x90,0x3C,0x64 -> Syn_key rises, Note=60, Velocity=100, single Note_valid pulse, 1 cycle after the last stop-bit sample.
2. Continue with running status 0x40,0x50 -> Syn_key low for exactly 1 cycle then high; Note=64, Velocity=80; one Note_valid pulse.
3. Send 0x3C,0x00 (running Note On, vel 0, not the held note) -> no change. Then 0x80,0x40,0x00 -> Syn_key=0; Note stays 64.
4. Send 0x91,0x3C,0x64 -> no output change. Then 0x90,0xF8,0x30,0xFE,0x7F -> Syn_key=1, Note=48, Velocity=127.
5. Drive a byte with a low stop bit mid-message -> one Rx_err pulse, byte dropped. A following valid 2nd data byte still completes the message. A 1.2-bit start glitch -> no byte, no Rx_err.
6. Assert Midi_rst_n=0 mid-DATA with Syn_key=1 -> all outputs 0 immediately. Drop Midi_ce mid-byte, re-enable, resend a full message -> decoded correctly.
